// File: rtl/fg_pkg.sv
// Shared function-generator definitions: default config-register geometry and the
// commit scheduler state encoding, also used by generator-level benches.
package fg_pkg;

    localparam int FG_NUM_REGS      = 8;
    localparam int FG_REG_WIDTH     = 8;
    localparam int FG_ADDR_WIDTH    = 3;
    localparam int FG_TIMEOUT_WIDTH = 10;

    localparam logic FG_ST_IDLE  = 1'b0;
    localparam logic FG_ST_ARMED = 1'b1;

    typedef enum logic {
        ST_IDLE  = FG_ST_IDLE,
        ST_ARMED = FG_ST_ARMED
    } fg_state_e;

endpackage

// File: rtl/fg_edge_detect.sv
// Rising-edge detector: one-cycle pulse on the first sampled high of a level input.
module fg_edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic sig,
    output logic rise
);

    logic prev_r;

    // Remember the previous sample of the level input
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sig;
        end
    end

    assign rise = sig & ~prev_r;

endmodule

// File: rtl/fg_config_scheduler.sv
// Shadow/active config register controller: host writes collect in shadow registers and
// are copied to the active CR bus in one edge at a period wrap, or when the arm times out.
module fg_config_scheduler
    import fg_pkg::*;
#(
    parameter int NUM_REGS      = FG_NUM_REGS,
    parameter int REG_WIDTH     = FG_REG_WIDTH,
    parameter int ADDR_WIDTH    = FG_ADDR_WIDTH,
    parameter int TIMEOUT_WIDTH = FG_TIMEOUT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          wrEnable_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [REG_WIDTH-1:0]          data_i,
    input  logic                          commitReq_i,
    input  logic                          periodWrap_i,
    output logic [NUM_REGS*REG_WIDTH-1:0] CR_bus_o,
    output logic                          outputEnable_o,
    output logic                          pending_o,
    output logic                          armed_o,
    output logic                          commitDone_o,
    output logic                          commitTimeout_o
);

    logic                     wr_rise_s;
    logic                     wr_hit_s;
    logic                     commit_s;
    logic                     forced_s;
    logic [REG_WIDTH-1:0]     shadow_r [NUM_REGS];
    fg_state_e                state_r;
    logic [TIMEOUT_WIDTH-1:0] cnt_r;

    fg_edge_detect u_wr_edge (
        .clk  (clk_i),
        .rstn (rstn_i),
        .sig  (wrEnable_i),
        .rise (wr_rise_s)
    );

    // Qualify a write edge against the implemented register range
    always_comb begin
        wr_hit_s = 1'b0;
        if (wr_rise_s && (int'(addr_i) < NUM_REGS)) begin
            wr_hit_s = 1'b1;
        end else begin
            wr_hit_s = 1'b0;
        end
    end

    // Commit decision; a wrap on the timeout cycle still counts as a normal commit
    always_comb begin
        commit_s = 1'b0;
        forced_s = 1'b0;
        if (state_r == ST_ARMED) begin
            if (periodWrap_i) begin
                commit_s = 1'b1;
            end else if (cnt_r == {TIMEOUT_WIDTH{1'b1}}) begin
                commit_s = 1'b1;
                forced_s = 1'b1;
            end else begin
                commit_s = 1'b0;
            end
        end else begin
            commit_s = 1'b0;
        end
    end

    // Shadow register file, written once per enable edge
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_r[i] <= {REG_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit_s && (int'(addr_i) == i)) begin
                    shadow_r[i] <= data_i;
                end
            end
        end
    end

    // Arm/commit FSM with timeout counter, active bus and registered status
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {TIMEOUT_WIDTH{1'b0}};
            CR_bus_o        <= {(NUM_REGS*REG_WIDTH){1'b0}};
            outputEnable_o  <= 1'b0;
            pending_o       <= 1'b0;
            armed_o         <= 1'b0;
            commitDone_o    <= 1'b0;
            commitTimeout_o <= 1'b0;
        end else begin
            commitDone_o    <= commit_s;
            commitTimeout_o <= forced_s;
            case (state_r)
                ST_IDLE: begin
                    if (commitReq_i) begin
                        state_r <= ST_ARMED;
                        armed_o <= 1'b1;
                        cnt_r   <= {TIMEOUT_WIDTH{1'b0}};
                    end
                end
                ST_ARMED: begin
                    if (commit_s) begin
                        state_r <= ST_IDLE;
                        armed_o <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + TIMEOUT_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    armed_o <= 1'b0;
                end
            endcase
            // A write landing on the commit edge stays in shadow, so the bus is still dirty
            if (commit_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    CR_bus_o[(NUM_REGS-1-i)*REG_WIDTH +: REG_WIDTH] <= shadow_r[i];
                end
                outputEnable_o <= 1'b1;
                pending_o      <= wr_hit_s;
            end else if (wr_hit_s) begin
                pending_o <= 1'b1;
            end
        end
    end

endmodule
